operand_deserializer: RTL

Serial-in, parallel-out input stage feeding the FP adder core. It shifts in two 32-bit IEEE-754 single-precision operands, A then B, one bit per accepted strobe, LSB first. This is the same bit order in which the output register shifts results out. It then presents both operands in parallel to the adder with a valid/ready handshake. Partial frames are held in internal shadow registers, so the parallel outputs change only when a complete operand pair is published.

---
 rtl/operand_deserializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/operand_deserializer.sv
// operand_deserializer: shifts two WIDTH-bit operands in LSB first (A, then B)
// and publishes them as a parallel pair to the adder under a valid/ready handshake.
module operand_deserializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             serial_in,
  input  logic             serial_valid_in,
  input  logic             clear_in,
  input  logic             adder_rdy_in,
  output logic             input_rdy,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             operands_valid,
  output logic             loading_b
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] shadow_a, shadow_a_n;
  logic [WIDTH-1:0] shadow_b, shadow_b_n;
  logic [WIDTH-1:0] operand_a_n, operand_b_n;
  logic             operands_valid_n, input_rdy_n, loading_b_n;

  logic accept;
  logic last_bit;

  assign accept   = serial_valid_in && input_rdy;
  assign last_bit = (count == CW'(WIDTH - 1));

  // Next-state and next-output decode; clear beats any same-cycle bit or handshake.
  always_comb begin
    state_n          = state;
    count_n          = count;
    shadow_a_n       = shadow_a;
    shadow_b_n       = shadow_b;
    operand_a_n      = operand_a;
    operand_b_n      = operand_b;
    operands_valid_n = operands_valid;
    input_rdy_n      = input_rdy;
    loading_b_n      = loading_b;
    if (clear_in) begin
      state_n          = LOAD_A;
      count_n          = '0;
      shadow_a_n       = '0;
      shadow_b_n       = '0;
      operands_valid_n = 1'b0;
      input_rdy_n      = 1'b1;
      loading_b_n      = 1'b0;
    end else begin
      unique case (state)
        LOAD_A: if (accept) begin
          shadow_a_n = {serial_in, shadow_a[WIDTH-1:1]};
          if (last_bit) begin
            count_n     = '0;
            state_n     = LOAD_B;
            loading_b_n = 1'b1;
          end else begin
            count_n = count + CW'(1);
          end
        end
        LOAD_B: if (accept) begin
          shadow_b_n = {serial_in, shadow_b[WIDTH-1:1]};
          if (last_bit) begin
            // Publish the pair; the final bit goes straight into operand_b.
            operand_a_n      = shadow_a;
            operand_b_n      = {serial_in, shadow_b[WIDTH-1:1]};
            operands_valid_n = 1'b1;
            input_rdy_n      = 1'b0;
            loading_b_n      = 1'b0;
            count_n          = '0;
            state_n          = HOLD;
          end else begin
            count_n = count + CW'(1);
          end
        end
        HOLD: if (operands_valid && adder_rdy_in) begin
          // Operands stay on the bus after the handshake; only valid drops.
          operands_valid_n = 1'b0;
          input_rdy_n      = 1'b1;
          state_n          = LOAD_A;
        end
        default: begin
          state_n     = LOAD_A;
          count_n     = '0;
          input_rdy_n = 1'b1;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset at top priority.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= LOAD_A;
      count          <= '0;
      shadow_a       <= '0;
      shadow_b       <= '0;
      operand_a      <= '0;
      operand_b      <= '0;
      operands_valid <= 1'b0;
      input_rdy      <= 1'b1;
      loading_b      <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      shadow_a       <= shadow_a_n;
      shadow_b       <= shadow_b_n;
      operand_a      <= operand_a_n;
      operand_b      <= operand_b_n;
      operands_valid <= operands_valid_n;
      input_rdy      <= input_rdy_n;
      loading_b      <= loading_b_n;
    end
  end

endmodule
